// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared state, mux-owner and error-code constants for the SIFT sequencer
package sift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAUSS  = 3'd1,
    ST_DETECT = 3'd2,
    ST_MATCH  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } sift_state_e;

  // Shared SRAM / line-buffer owner codes, also decoded by the top-level address mux.
  localparam logic [1:0] MUX_NONE   = 2'd0;
  localparam logic [1:0] MUX_GAUSS  = 2'd1;
  localparam logic [1:0] MUX_DETECT = 2'd2;
  localparam logic [1:0] MUX_MATCH  = 2'd3;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_GAUSS  = 2'd1;
  localparam logic [1:0] ERR_DETECT = 2'd2;
  localparam logic [1:0] ERR_MATCH  = 2'd3;

  function automatic logic is_phase(input sift_state_e s);
    return (s == ST_GAUSS) || (s == ST_DETECT) || (s == ST_MATCH);
  endfunction

  function automatic logic [1:0] phase_mux(input sift_state_e s);
    case (s)
      ST_GAUSS:  return MUX_GAUSS;
      ST_DETECT: return MUX_DETECT;
      ST_MATCH:  return MUX_MATCH;
      default:   return MUX_NONE;
    endcase
  endfunction

  function automatic logic [1:0] phase_err(input sift_state_e s);
    case (s)
      ST_GAUSS:  return ERR_GAUSS;
      ST_DETECT: return ERR_DETECT;
      ST_MATCH:  return ERR_MATCH;
      default:   return ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sift_sequencer_if.sv
// rtl/sift_sequencer_if.sv - control, engine handshake and status bundle of the SIFT sequencer
interface sift_sequencer_if #(
  parameter int KPT_W = 11
);

  logic             start;
  logic             abort;
  logic             clear;
  logic             gauss_done;
  logic             detect_done;
  logic             match_done;
  logic [KPT_W-1:0] detect_kpt_addr;

  logic             gauss_start;
  logic             detect_start;
  logic             match_start;
  logic [1:0]       mux_sel;
  logic [KPT_W-1:0] kpt_num;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [31:0]      run_cycles;

  modport master (
    output start, abort, clear, gauss_done, detect_done, match_done, detect_kpt_addr,
    input  gauss_start, detect_start, match_start, mux_sel, kpt_num,
           busy, done, error, err_code, run_cycles
  );

  modport slave (
    input  start, abort, clear, gauss_done, detect_done, match_done, detect_kpt_addr,
    output gauss_start, detect_start, match_start, mux_sel, kpt_num,
           busy, done, error, err_code, run_cycles
  );

endinterface

// File: rtl/sift_sequencer_watchdog.sv
// rtl/sift_sequencer_watchdog.sv - per-phase watchdog counter, expires at all-ones
module phase_watchdog #(
  parameter int TO_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count_q, count_d;

  // Holds at all-ones so expired stays asserted until the owner clears it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = &count_q;

endmodule

// File: rtl/sift_sequencer.sv
// rtl/sift_sequencer.sv - blur/detect/match phase sequencer with watchdog and run capture
module sift_sequencer
  import sift_pkg::*;
#(
  parameter int TO_W  = 24,
  parameter int KPT_W = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sift_sequencer_if.slave      bus
);

  sift_state_e      state_q, state_d;
  logic [KPT_W-1:0] kpt_q, kpt_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [1:0]       err_q, err_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;
  logic run_start;
  logic timeout;
  logic busy_w;

  phase_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Priority inside a phase: abort, then that phase's done, then timeout.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_GAUSS;
      end
      ST_GAUSS: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.gauss_done) begin
          state_d = ST_DETECT;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
          timeout = 1'b1;
        end
      end
      ST_DETECT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.detect_done) begin
          state_d = ST_MATCH;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
          timeout = 1'b1;
        end
      end
      ST_MATCH: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.match_done) begin
          state_d = ST_DONE;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
          timeout = 1'b1;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (bus.clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_w    = is_phase(state_q);
  assign run_start = (state_q == ST_IDLE) && bus.start;
  assign wd_clear  = is_phase(state_d) && (state_d != state_q);
  assign wd_enable = busy_w;

  always_comb begin
    kpt_d = kpt_q;
    cyc_d = cyc_q;
    err_d = err_q;
    if (run_start) begin
      kpt_d = '0;
      cyc_d = '0;
      err_d = ERR_NONE;
    end else begin
      if (state_q == ST_DETECT) kpt_d = bus.detect_kpt_addr;
      if (busy_w && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
      if (timeout) err_d = phase_err(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kpt_q   <= '0;
      cyc_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      kpt_q   <= kpt_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  // Engine enables decode straight from the state register so reset drops them at once.
  always_comb begin
    bus.gauss_start  = (state_q == ST_GAUSS);
    bus.detect_start = (state_q == ST_DETECT);
    bus.match_start  = (state_q == ST_MATCH);
    bus.mux_sel      = phase_mux(state_q);
    bus.busy         = busy_w;
    bus.done         = (state_q == ST_DONE);
    bus.error        = (state_q == ST_ERROR);
    bus.kpt_num      = kpt_q;
    bus.run_cycles   = cyc_q;
    bus.err_code     = err_q;
  end

endmodule

// File: doc/sift_sequencer.md
SIFT_SEQUENCER -- requirements
Module: sift_sequencer

Interface
REQ-001 Parameter TO_W, default 24: width of the per-phase watchdog counter.
REQ-002 Parameter KPT_W, default 11: width of the keypoint count.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Ports start, abort and clear, input, 1 each: start runs the pipeline, abort cancels an active run, clear acknowledges DONE/ERROR.
REQ-006 Ports gauss_done, detect_done and match_done, input, 1 each: phase-complete strobes from the blur, detect/filter and descriptor/match engines.
REQ-007 Port detect_kpt_addr, input, KPT_W: running keypoint write address from the detect engine.
REQ-008 Ports gauss_start, detect_start and match_start, output, 1 each: level enables for the three engines.
REQ-009 Port mux_sel, output, 2: shared-SRAM/line-buffer owner; 0 none, 1 gauss, 2 detect, 3 match.
REQ-010 Port kpt_num, output, KPT_W: captured keypoint count.
REQ-011 Ports busy, done and error, output, 1 each; err_code, output, 2: phase that timed out (1 gauss, 2 detect, 3 match).
REQ-012 Port run_cycles, output, 32: cycles of the last or current run.

Function
REQ-013 States SHALL be IDLE, GAUSS, DETECT, MATCH, DONE and ERROR.
REQ-014 IDLE SHALL go to GAUSS on start; start SHALL be ignored in every other state.
REQ-015 GAUSS SHALL go to DETECT on gauss_done, DETECT to MATCH on detect_done, and MATCH to DONE on match_done; a done strobe SHALL be sampled only in its own phase state.
REQ-016 Each xx_start SHALL be 1 exactly while in its phase state, so the next phase's start rises the cycle after the previous phase's done, with zero gap cycles.
REQ-017 mux_sel SHALL equal the phase code in GAUSS, DETECT and MATCH, and 0 otherwise.
REQ-018 busy SHALL be 1 in GAUSS, DETECT and MATCH; done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-019 DONE and ERROR SHALL hold until clear, then go to IDLE; in these states start without clear SHALL be ignored.
REQ-020 On entry to each phase state a TO_W-bit watchdog SHALL be zeroed, then increment every cycle in that phase.
REQ-021 If the watchdog reaches all-ones with no done strobe, the block SHALL go to ERROR next cycle, latch err_code with the phase, and drop all starts.
REQ-022 Simultaneous events: abort SHALL beat done and timeout; done SHALL beat timeout.
REQ-023 abort in GAUSS, DETECT or MATCH SHALL go to IDLE next cycle, with all starts 0 and no error; in other states it SHALL have no effect.
REQ-024 kpt_num SHALL clear on the IDLE to GAUSS transition, load detect_kpt_addr every cycle in DETECT, and hold afterwards, including through DONE and abort.
REQ-025 run_cycles SHALL clear on IDLE to GAUSS, increment while busy, saturate at all-ones, and hold otherwise.
REQ-026 err_code SHALL clear on the IDLE to GAUSS transition.

Reset
REQ-027 When rst_n is 0, the block SHALL enter IDLE asynchronously and zero all outputs and counters.
REQ-028 Reset mid-phase SHALL drop every xx_start immediately, without waiting for a clock edge.
REQ-029 The first clock edge after rst_n rises SHALL evaluate start normally.

Structure
REQ-030 State encodings, mux_sel codes and err_code values SHALL live in the shared package sift_pkg, so the top-level SRAM address mux decodes mux_sel from the same constants.
REQ-031 The watchdog SHALL be a single sub-module, phase_watchdog (inputs clear, enable; output expired), parameterised by TO_W.
REQ-032 The state machine and capture registers SHALL stay in sift_sequencer.

Verification
REQ-033 Nominal run: start; gauss_done at cycle 10, detect_done at 25 with detect_kpt_addr=37, match_done at 40 -> starts rise on consecutive cycles, mux_sel goes 1,2,3, done=1, kpt_num=37, run_cycles=40 (+/-1 per defined edge).
REQ-034 Timeout with TO_W=4: start, no gauss_done -> ERROR after 16 GAUSS cycles, err_code=1, gauss_start=0; clear -> IDLE with error=0.
REQ-035 Abort priority: abort and detect_done in the same cycle -> IDLE, match_start never rises, error=0.
REQ-036 Start filtering: start pulses during MATCH and during DONE -> no effect; done remains 1 until clear.
REQ-037 Async reset: rst_n low mid-DETECT between clock edges -> detect_start=0 and kpt_num=0 before the next edge.
REQ-038 Simultaneous done and timeout with TO_W=4: match_done on the all-ones watchdog cycle -> DONE, not ERROR.
